id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline stage directly upstream of the execute ALU.
- Registers decoded operands and control, and applies operand forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards, inserts bubbles and honours branch flush.
- Drives alu_in1, alu_in2, Opcode and inval for the execute stage.

Parameters:
- DW, 16, datapath width.
- RW, 4, register-index width (16 registers; R0 reads zero and is never forwarded).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset: asynchronous, active-low.
- id_valid  in  1  decode slot holds a real instruction.
- id_opcode  in  4  decoded opcode.
- id_rs, id_rt, id_rd  in  RW each  source and destination indices. For LLB/LHB, id_rt carries the rd index.
- id_rs_data, id_rt_data  in  DW each  register-file read data.
- id_imm  in  DW  sign/zero-extended immediate.
- id_use_imm  in  1  operand 2 comes from id_imm.
- id_mem_read, id_reg_write  in  1 each  load flag and writeback flag.
- flush  in  1  branch redirect; kill the decode-slot instruction.
- exm_reg_write, exm_rd, exm_data  in  1/RW/DW  EX/MEM result bus.
- mwb_reg_write, mwb_rd, mwb_data  in  1/RW/DW  MEM/WB result bus.
- alu_in1, alu_in2  out  DW  forwarded ALU operands.
- opcode  out  4  registered opcode.
- inval  out  1  registered valid; ALU flag write enable.
- ex_rd  out  RW  registered destination index.
- ex_reg_write, ex_mem_read  out  1 each  registered control.
- stall  out  1  combinational; decode and fetch must hold.

Behaviour:
- Reset values (async, rst=0): all registered outputs 0, inval=0, and the internal operand/imm registers 0. Leaving reset is synchronous to the next edge.
- Latency: one cycle from decode inputs to registered outputs. Forward muxing on alu_in1/alu_in2 is combinational on the current exm/mwb buses.
- Load-use hazard: stall=1 when all of the following hold:
  - id_valid and inval and ex_mem_read;
  - ex_rd != 0;
  - ex_rd == id_rs, or (ex_rd == id_rt and the rt operand is used).
- Stall response: the stage captures a bubble (inval=0, ex_reg_write=0, ex_mem_read=0) and decode holds. Exactly one bubble per hazard.
- Flush: the next edge captures a bubble and stall is forced 0. Flush wins over stall.
- Capture-time bypass: if mwb_reg_write and mwb_rd == the source index (nonzero), the captured data is mwb_data instead of the register-file data. This covers the write-read same cycle case.
- Execute-time forwarding, per operand, priority order:
  1. EX/MEM match (exm_reg_write, exm_rd nonzero and equal to the registered source).
  2. MEM/WB match.
  3. Registered data.
- Operand mapping:
  - Opcode 101x (LLB/LHB): alu_in1 = registered imm; alu_in2 = forwarded rt operand.
  - Otherwise: alu_in1 = forwarded rs; alu_in2 = registered imm when use_imm, else forwarded rt.
- Source index 0 always yields 0, with no forwarding.
- A bubble still drives registered opcode/operands, but inval=0 so ALU flags do not update.
- A mid-operation reset discards the in-flight instruction; the first post-reset cycle is a bubble.

Optional Feature:
- Macro: ID_EX_STAGE_PERF_EN.
- With it: two 16-bit saturating counters, stall_cnt and flush_cnt.
  - Each increments on edges where stall or flush (respectively) is high; saturates at 16'hFFFF.
  - Both clear on reset.
  - Exposed as output ports perf_stall_cnt and perf_flush_cnt.
- Without it: the counters and ports are absent; behaviour is otherwise identical.

Decomposition:
- Package wisc_pkg holds:
  - opcode constants (OPC_LLB=4'hA, OPC_LHB=4'hB, OPC_LW, OPC_SW);
  - a DW/RW localparam set;
  - an IS_BYTELOAD(opcode) function.
- One natural sub-module, fwd_mux: source index, registered data, exm/mwb buses in; forwarded operand out. Instantiated twice.

Test Plan:
1. Reset: rst=0 mid-stream with inval=1 -> all outputs 0 immediately (async); first edge after release shows inval=0.
2. EX/MEM forward: ADD R3 followed by SUB using R3, with exm_rd=3 and exm_data=16'h1234 -> alu_in1=16'h1234. If mwb_rd=3 at the same time with 16'h5555, EX/MEM still wins.
3. Load-use: LW R5 in EX, decode ADD R6,R5,R1 -> stall=1 for exactly one cycle; the next cycle has inval=0; ADD then executes with alu_in1 = mwb_data.
4. Flush with stall: load-use condition plus flush=1 -> stall=0 and a bubble is captured; the killed instruction never appears with inval=1.
5. LLB: opcode 4'hA, imm=16'h00AB, rt=R4 forwarded 16'hFF00 from exm -> alu_in1=16'h00AB, alu_in2=16'hFF00.
6. R0 rule: id_rs=0 with exm_rd=0, exm_reg_write=1, exm_data=16'hDEAD -> alu_in1=0. With ID_EX_STAGE_PERF_EN, 3 stalls -> perf_stall_cnt=3.

Source files
------------

// File: rtl/wisc_pkg.sv
// Shared opcode constants, width defaults and decode helpers for the WISC pipeline.
package wisc_pkg;

  localparam int unsigned WISC_DW = 16;
  localparam int unsigned WISC_RW = 4;

  localparam logic [3:0] OPC_LW  = 4'h8;
  localparam logic [3:0] OPC_SW  = 4'h9;
  localparam logic [3:0] OPC_LLB = 4'hA;
  localparam logic [3:0] OPC_LHB = 4'hB;

  function automatic logic IS_BYTELOAD(input logic [3:0] opc);
    return (opc == OPC_LLB) || (opc == OPC_LHB);
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Per-operand execute-time forwarding: EX/MEM beats MEM/WB beats the registered value.
module fwd_mux
  import wisc_pkg::*;
#(
  parameter int unsigned DW = WISC_DW,
  parameter int unsigned RW = WISC_RW
) (
  input  logic [RW-1:0] src,
  input  logic [DW-1:0] reg_data,
  input  logic          exm_reg_write,
  input  logic [RW-1:0] exm_rd,
  input  logic [DW-1:0] exm_data,
  input  logic          mwb_reg_write,
  input  logic [RW-1:0] mwb_rd,
  input  logic [DW-1:0] mwb_data,
  output logic [DW-1:0] fwd_data
);

  always_comb begin
    fwd_data = reg_data;
    // R0 is hardwired to zero and never takes a forwarded value
    if (src == '0) begin
      fwd_data = '0;
    end else if (exm_reg_write && (exm_rd == src)) begin
      fwd_data = exm_data;
    end else if (mwb_reg_write && (mwb_rd == src)) begin
      fwd_data = mwb_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use stall and flush bubbles.
// Optional perf counters for stalls and flushes are built when ID_EX_STAGE_PERF_EN is defined.
module id_ex_stage
  import wisc_pkg::*;
#(
  parameter int unsigned DW = WISC_DW,
  parameter int unsigned RW = WISC_RW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [3:0]    id_opcode,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic          id_use_imm,
  input  logic          id_mem_read,
  input  logic          id_reg_write,
  input  logic          flush,
  input  logic          exm_reg_write,
  input  logic [RW-1:0] exm_rd,
  input  logic [DW-1:0] exm_data,
  input  logic          mwb_reg_write,
  input  logic [RW-1:0] mwb_rd,
  input  logic [DW-1:0] mwb_data,
  output logic [DW-1:0] alu_in1,
  output logic [DW-1:0] alu_in2,
  output logic [3:0]    opcode,
  output logic          inval,
  output logic [RW-1:0] ex_rd,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          stall
`ifdef ID_EX_STAGE_PERF_EN
  ,
  output logic [15:0]   perf_stall_cnt,
  output logic [15:0]   perf_flush_cnt
`endif
);

  logic          live_q;
  logic          valid_q, reg_write_q, mem_read_q, use_imm_q;
  logic [3:0]    opcode_q;
  logic [RW-1:0] rd_q, rs_q, rt_q;
  logic [DW-1:0] rs_data_q, rt_data_q, imm_q;

  logic          rt_used;
  logic          capture;
  logic [DW-1:0] rs_cap, rt_cap;
  logic [DW-1:0] rs_fwd, rt_fwd;

  // LLB/LHB read their destination through rt, so rt is live for them too
  assign rt_used = !id_use_imm || IS_BYTELOAD(id_opcode);

  assign stall = !flush && id_valid && valid_q && mem_read_q && (rd_q != '0) &&
                 ((rd_q == id_rs) || ((rd_q == id_rt) && rt_used));

  // The first edge after reset release always captures a bubble
  assign capture = id_valid && !stall && !flush && live_q;

  // Same-cycle writeback bypass into the captured operand
  assign rs_cap = ((id_rs != '0) && mwb_reg_write && (mwb_rd == id_rs)) ? mwb_data : id_rs_data;
  assign rt_cap = ((id_rt != '0) && mwb_reg_write && (mwb_rd == id_rt)) ? mwb_data : id_rt_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live_q      <= 1'b0;
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      use_imm_q   <= 1'b0;
      opcode_q    <= '0;
      rd_q        <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
    end else begin
      live_q      <= 1'b1;
      valid_q     <= capture;
      reg_write_q <= capture && id_reg_write;
      mem_read_q  <= capture && id_mem_read;
      use_imm_q   <= id_use_imm;
      opcode_q    <= id_opcode;
      rd_q        <= IS_BYTELOAD(id_opcode) ? id_rt : id_rd;
      rs_q        <= id_rs;
      rt_q        <= id_rt;
      rs_data_q   <= rs_cap;
      rt_data_q   <= rt_cap;
      imm_q       <= id_imm;
    end
  end

  fwd_mux #(
    .DW (DW),
    .RW (RW)
  ) u_fwd_rs (
    .src           (rs_q),
    .reg_data      (rs_data_q),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .exm_data      (exm_data),
    .mwb_reg_write (mwb_reg_write),
    .mwb_rd        (mwb_rd),
    .mwb_data      (mwb_data),
    .fwd_data      (rs_fwd)
  );

  fwd_mux #(
    .DW (DW),
    .RW (RW)
  ) u_fwd_rt (
    .src           (rt_q),
    .reg_data      (rt_data_q),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .exm_data      (exm_data),
    .mwb_reg_write (mwb_reg_write),
    .mwb_rd        (mwb_rd),
    .mwb_data      (mwb_data),
    .fwd_data      (rt_fwd)
  );

  always_comb begin
    alu_in1 = rs_fwd;
    alu_in2 = use_imm_q ? imm_q : rt_fwd;
    if (IS_BYTELOAD(opcode_q)) begin
      alu_in1 = imm_q;
      alu_in2 = rt_fwd;
    end
  end

  assign opcode       = opcode_q;
  assign inval        = valid_q;
  assign ex_rd        = rd_q;
  assign ex_reg_write = reg_write_q;
  assign ex_mem_read  = mem_read_q;

`ifdef ID_EX_STAGE_PERF_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (flush && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule
